// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the EX-stage controller and the multiply/divide unit.
// The master drives the request; the slave returns status and the HI/LO registers.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle on
// operand magnitudes, then one sign-fix cycle that writes HI/LO and pulses done.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  mdu
);
  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic             is_div_q, sign_a_q, sign_b_q, b_zero_q;
  logic [WIDTH-1:0] a_q, opnd_q, acc_hi_q, acc_lo_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0]   a_mag, b_mag, div_sub, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // op[0] marks the signed variants (MULT, DIV).
  always_comb begin
    a_mag    = (mdu.op[0] && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
    b_mag    = (mdu.op[0] && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;
    mul_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, opnd_q};
    // The restored remainder is always below the divisor, so the low bits suffice.
    div_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
    rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mdu.start) begin
            is_div_q <= mdu.op[1];
            sign_a_q <= mdu.op[0] & mdu.a[WIDTH-1];
            sign_b_q <= mdu.op[0] & mdu.b[WIDTH-1];
            b_zero_q <= (mdu.b == '0);
            a_q      <= mdu.a;
            opnd_q   <= b_mag;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (is_div_q) begin
            acc_hi_q <= div_ge ? div_sub : rem_sh[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          count_q <= count_q + 1'b1;
          if (count_q == CntW'(ITER - 1)) state_q <= StFix;
        end
        StFix: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (b_zero_q) begin
            hi_q  <= a_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mdu.busy        = busy_q;
  assign mdu.done        = done_q;
  assign mdu.div_by_zero = dbz_q;
  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;
endmodule
